// File: rtl/aes_cikis_tamponu_if.sv
// Handshake bundle between the AES engine, its upstream source and the
// ciphertext output buffer.
interface aes_cikis_tamponu_if #(
  parameter int DEPTH = 4
);
  logic                     kaynak_gecerli;
  logic                     kaynak_hazir;
  logic                     hazir;
  logic                     g_gecerli;
  logic [127:0]             sifre;
  logic [127:0]             cikis_veri;
  logic                     cikis_gecerli;
  logic                     cikis_hazir;
  logic [$clog2(DEPTH):0]   doluluk;
  logic                     tasma;

  modport slave (
    input  kaynak_gecerli, hazir, sifre, cikis_hazir,
    output kaynak_hazir, g_gecerli, cikis_veri, cikis_gecerli, doluluk, tasma
  );

  modport master (
    output kaynak_gecerli, hazir, sifre, cikis_hazir,
    input  kaynak_hazir, g_gecerli, cikis_veri, cikis_gecerli, doluluk, tasma
  );
endinterface

// File: rtl/aes_cikis_tamponu.sv
// Credit-gated output buffer for the non-stallable AES-128 round pipeline:
// tracks admitted blocks through a valid delay line and captures into a FWFT FIFO.
module aes_cikis_tamponu #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 4
) (
  input logic                clk,
  input logic                rst,
  aes_cikis_tamponu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [LATENCY-1:0] d;
  logic [127:0]       mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      doluluk_q;
  logic [CW-1:0]      ayrilan;
  logic               tasma_q;

  logic kaynak_hazir;
  logic accept;
  logic bos_degil;
  logic pop;
  logic capture;
  logic write;
  logic overflow;

  // Credits come from registered state only, so a pop frees a slot one cycle later.
  assign kaynak_hazir = bus.hazir && (ayrilan < FULL);
  assign accept       = bus.kaynak_gecerli && kaynak_hazir;
  assign bos_degil    = (doluluk_q != '0);
  assign pop          = bos_degil && bus.cikis_hazir;
  assign capture      = d[LATENCY-1];
  assign write        = capture && ((doluluk_q != FULL) || pop);
  assign overflow     = capture && (doluluk_q == FULL) && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d         <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      doluluk_q <= '0;
      ayrilan   <= '0;
      tasma_q   <= 1'b0;
    end else begin
      d <= {d[LATENCY-2:0], accept};
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);

      if (accept && !pop)      ayrilan <= ayrilan + CW'(1);
      else if (pop && !accept) ayrilan <= ayrilan - CW'(1);

      if (write && !pop)      doluluk_q <= doluluk_q + CW'(1);
      else if (pop && !write) doluluk_q <= doluluk_q - CW'(1);

      if (overflow) tasma_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= bus.sifre;
  end

  assign bus.kaynak_hazir  = kaynak_hazir;
  assign bus.g_gecerli     = accept;
  assign bus.cikis_gecerli = bos_degil;
  assign bus.cikis_veri    = bos_degil ? mem[rd_ptr] : '0;
  assign bus.doluluk       = doluluk_q;
  assign bus.tasma         = tasma_q;
endmodule
